// File: rtl/sdu_tx_sched.sv
// sdu_tx_sched: shares one UART transmitter between a raw-byte requester and a hex-word printer.
// Build option: define SDU_TX_PREFIX_EN to emit "0x" before every word (states PFX0/PFX1).
module sdu_tx_sched #(
   parameter int HEX_DIGITS = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        b_vld,
   output logic        b_rdy,
   input  logic [7:0]  b_data,
   input  logic        w_vld,
   output logic        w_rdy,
   input  logic [31:0] w_data,
   input  logic        w_nl,
   output logic        vld_tx,
   input  logic        rdy_tx,
   output logic [7:0]  d_tx,
   output logic        busy
);

`ifdef SDU_TX_PREFIX_EN
   typedef enum logic [2:0] {IDLE, BYTE, PFX0, PFX1, HEX, CR, LF} state_t;
`else
   typedef enum logic [2:0] {IDLE, BYTE, HEX, CR, LF} state_t;
`endif

   localparam logic [2:0] CNT_LOAD  = 3'(HEX_DIGITS - 1);
   localparam logic       LAST_BYTE = 1'b0;
   localparam logic       LAST_WORD = 1'b1;

   state_t      state, state_nxt;
   logic        last, last_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic [7:0]  byte_q;
   logic [31:0] word_q;
   logic        nl_q;
   logic        grant_b, grant_w;
   logic [3:0]  nib;

   // 0..9 -> '0'..'9', 10..15 -> 'A'..'F'
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'd0, n};
      else
         return 8'h37 + {4'd0, n};
   endfunction

   // Ties alternate: whoever was served last yields. Gated by rstn so nothing is granted in reset.
   assign grant_b = rstn && (state == IDLE) && b_vld && (!w_vld || last == LAST_WORD);
   assign grant_w = rstn && (state == IDLE) && w_vld && (!b_vld || last == LAST_BYTE);

   assign nib  = word_q[{cnt, 2'b00} +: 4];
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         last  <= LAST_WORD;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Request payloads are captured only in the accept cycle.
   always_ff @(posedge clk) begin
      if (grant_b)
         byte_q <= b_data;
      if (grant_w) begin
         word_q <= w_data;
         nl_q   <= w_nl;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = cnt;
      vld_tx    = 1'b0;
      d_tx      = 8'h00;
      b_rdy     = 1'b0;
      w_rdy     = 1'b0;
      case (state)
         IDLE: begin
            b_rdy = grant_b;
            w_rdy = grant_w;
            if (grant_b) begin
               state_nxt = BYTE;
               last_nxt  = LAST_BYTE;
            end else if (grant_w) begin
`ifdef SDU_TX_PREFIX_EN
               state_nxt = PFX0;
`else
               state_nxt = HEX;
`endif
               last_nxt  = LAST_WORD;
               cnt_nxt   = CNT_LOAD;
            end
         end
         BYTE: begin
            vld_tx = 1'b1;
            d_tx   = byte_q;
            if (rdy_tx)
               state_nxt = IDLE;
         end
`ifdef SDU_TX_PREFIX_EN
         PFX0: begin
            vld_tx = 1'b1;
            d_tx   = 8'h30;
            if (rdy_tx)
               state_nxt = PFX1;
         end
         PFX1: begin
            vld_tx = 1'b1;
            d_tx   = 8'h78;
            if (rdy_tx)
               state_nxt = HEX;
         end
`endif
         HEX: begin
            vld_tx = 1'b1;
            d_tx   = hex_ascii(nib);
            if (rdy_tx) begin
               cnt_nxt = cnt - 3'd1;
               if (cnt == 3'd0)
                  state_nxt = nl_q ? CR : IDLE;
            end
         end
         CR: begin
            vld_tx = 1'b1;
            d_tx   = 8'h0D;
            if (rdy_tx)
               state_nxt = LF;
         end
         LF: begin
            vld_tx = 1'b1;
            d_tx   = 8'h0A;
            if (rdy_tx)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
